aes_enc_round_sequencer: RTL and testbench

//  Iterative AES encryption controller. Accepts one 128-bit plaintext block per transaction,

---
 rtl/aes_enc_round_sequencer.sv | 135 +++++++++++++
 tb/tb_aes_enc_round_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : aes_enc_round_sequencer
// Brief   : Iterative AES encryption control; initial AddRoundKey, then NR
//           rounds through one shared external round datapath.
// Revision: 1.0
// ============================================================================
module aes_enc_round_sequencer #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic [3:0]   key_idx,
    input  logic         key_vld,
    input  logic [127:0] rk_in,
    output logic         dp_start,
    output logic [127:0] dp_block,
    output logic [127:0] dp_key,
    output logic [3:0]   dp_round,
    output logic         dp_final,
    input  logic         dp_done,
    input  logic [127:0] dp_result,
    output logic         busy,
    output logic         err
);

    localparam int                c_tmo_w    = $clog2(TIMEOUT);
    localparam logic [3:0]        c_nr       = 4'(NR);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_KEY0 = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [127:0]         state_reg_q, state_reg_d;
    logic [3:0]           round_cnt_q, round_cnt_d;
    logic [c_tmo_w-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic w_last_round;
    logic w_timeout;

    assign w_last_round = (round_cnt_q == c_nr);
    // dp_done in the timeout cycle takes priority, so it suppresses the abort.
    assign w_timeout    = (state_q == S_WAIT) && !dp_done && (tmo_cnt_q == c_tmo_last);

    always_comb begin
        state_d     = state_q;
        state_reg_d = state_reg_q;
        round_cnt_d = round_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_reg_d = in_block;
                    round_cnt_d = 4'd0;
                    state_d     = S_KEY0;
                end
            end
            S_KEY0: begin
                if (key_vld) begin
                    state_reg_d = state_reg_q ^ rk_in;
                    round_cnt_d = 4'd1;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (key_vld) begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dp_done) begin
                    state_reg_d = dp_result;
                    if (w_last_round) begin
                        state_d = S_OUT;
                    end else begin
                        round_cnt_d = round_cnt_q + 4'd1;
                        state_d     = S_REQ;
                    end
                end else if (w_timeout) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + c_tmo_w'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            state_reg_q <= '0;
            round_cnt_q <= 4'd0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            state_reg_q <= state_reg_d;
            round_cnt_q <= round_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_block = state_reg_q;
    assign dp_block  = state_reg_q;
    assign dp_round  = round_cnt_q;
    assign key_idx   = (state_q == S_REQ) ? round_cnt_q : 4'd0;
    assign dp_start  = (state_q == S_REQ) && key_vld;
    assign dp_key    = dp_start ? rk_in : 128'd0;
    assign dp_final  = dp_start && w_last_round;
    assign err       = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_enc_round_sequencer
// Brief   : Scoreboard bench with key-store and round-datapath responders.
// Revision: 1.0
// ============================================================================
module tb_aes_enc_round_sequencer;

    localparam int NR      = 10;
    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic [3:0]   key_idx;
    logic         key_vld;
    logic [127:0] rk_in;
    logic         dp_start;
    logic [127:0] dp_block;
    logic [127:0] dp_key;
    logic [3:0]   dp_round;
    logic         dp_final;
    logic         dp_done;
    logic [127:0] dp_result;
    logic         busy;
    logic         err;

    aes_enc_round_sequencer #(.NR(NR), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .key_idx(key_idx), .key_vld(key_vld), .rk_in(rk_in),
        .dp_start(dp_start), .dp_block(dp_block), .dp_key(dp_key),
        .dp_round(dp_round), .dp_final(dp_final), .dp_done(dp_done),
        .dp_result(dp_result), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_q[$];
    logic [127:0] rk_tab[16];
    logic [7:0]   sbox_t[256];
    bit           aes_mode     = 1'b0;
    int           stall_left   = 0;
    int           withhold_rnd = 0;
    int           hold_left    = 0;
    int           stall_obs    = 0;
    int           start4_obs   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference AES pieces (environment datapath) ----------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] blk, input logic [127:0] key,
                                               input logic fin);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = sbox_t[blk[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ key;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                     ^ {rc, 24'h000000};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] stub_exp(input logic [127:0] pt);
        logic [127:0] e;
        e = pt;
        for (int r = 0; r <= NR; r++) e = e ^ rk_tab[r];
        return e;
    endfunction

    // ---------------- responders -------------------------------------------
    initial begin
        key_vld = 1'b0;
        rk_in   = '0;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && key_idx == 4'd4) begin
                key_vld = 1'b0;
                stall_left--;
            end else begin
                key_vld = 1'b1;
            end
            rk_in = rk_tab[key_idx];
        end
    end

    initial begin
        logic [127:0] blk, k;
        logic         fin;
        logic [3:0]   rnd;
        dp_done   = 1'b0;
        dp_result = '0;
        forever begin
            @(negedge clk);
            if (dp_start === 1'b1) begin
                blk = dp_block; k = dp_key; fin = dp_final; rnd = dp_round;
                check_val("dp_key", k, rk_tab[rnd]);
                check_val("dp_final", 128'(fin), 128'(rnd == 4'(NR)));
                if (int'(rnd) != withhold_rnd) begin
                    @(posedge clk); #1;
                    dp_done   = 1'b1;
                    dp_result = aes_mode ? aes_round(blk, k, fin) : (blk ^ k);
                    @(posedge clk); #1;
                    dp_done   = 1'b0;
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (out_valid && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Scoreboard consumer and round-4 start monitor.
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (busy && key_idx == 4'd4 && !dp_start) stall_obs++;
            if (dp_start && dp_round == 4'd4) start4_obs++;
            if (out_valid && out_ready) begin
                check_val("sb_has_entry", 128'(exp_q.size() > 0), 128'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_val("out_block", out_block, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic send_block(input logic [127:0] pt, input logic [127:0] exp, input bit push,
                              output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("in_ready_wait", 128'(in_ready), 128'd1);
        if (push) exp_q.push_back(exp);
        in_valid = 1'b1;
        in_block = pt;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic wait_start(input logic [3:0] rnd);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dp_start && dp_round == rnd) && n < 300);
        check_val("start_seen", 128'(dp_start && dp_round == rnd), 128'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val(tag, {116'd0, in_ready, busy, out_valid, dp_start, dp_final, err, key_idx, dp_round},
                  {116'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0});
        check_val({tag, "_blocks"}, out_block | dp_block | dp_key, 128'd0);
    endtask

    // ---------------- main sequence ----------------------------------------
    initial begin
        int           n, acc_a, acc_b;
        logic [127:0] pt, pt2, cap, c0b;
        logic [7:0]   b;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_block = '0;
        for (int x = 0; x < 256; x++) sbox_t[x] = sbox_calc(8'(x));
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            rk_tab[i] = {16{b}};
        end

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset_n = 1'b1;

        // Zero block: latency and known stub ciphertext.
        b   = 8'h0b;
        c0b = {16{b}};
        send_block(128'd0, c0b, 1'b1, acc_a);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("latency_edges", 128'(n + 1), 128'(2 * NR + 2));
        wait_drain();

        // Back-to-back blocks: throughput.
        pt  = {$urandom, $urandom, $urandom, $urandom};
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, stub_exp(pt), 1'b1, acc_a);
        send_block(pt2, stub_exp(pt2), 1'b1, acc_b);
        check_val("throughput", 128'(acc_b - acc_a), 128'(2 * NR + 3));
        wait_drain();

        // Key not valid for 5 cycles in round 4.
        stall_obs  = 0;
        start4_obs = 0;
        stall_left = 5;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, stub_exp(pt), 1'b1, acc_a);
        wait_drain();
        check_val("stall_cycles", 128'(stall_obs), 128'd5);
        check_val("round4_starts", 128'(start4_obs), 128'd1);

        // Downstream back-pressure for 10 cycles.
        hold_left = 10;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, stub_exp(pt), 1'b1, acc_a);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        cap = out_block;
        for (int k = 0; k < 10; k++) begin
            check_val("hold_valid", 128'({out_valid, out_ready}), 128'(2'b10));
            check_val("hold_block", out_block, cap);
            check_val("hold_in_ready", 128'(in_ready), 128'd0);
            @(negedge clk);
        end
        check_val("handoff_in_ready", 128'({out_valid, in_ready}), 128'(2'b10));
        @(negedge clk);
        check_val("after_handoff", 128'({out_valid, in_ready}), 128'(2'b01));
        wait_drain();

        // Datapath never answers round 3.
        withhold_rnd = 3;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, 128'd0, 1'b0, acc_a);
        wait_start(4'd3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err && n < 200);
        check_val("timeout_cycles", 128'(n), 128'(TIMEOUT));
        @(negedge clk);
        check_val("after_timeout", 128'({err, busy, in_ready}), 128'(3'b001));
        withhold_rnd = 0;

        // Asynchronous reset during round 6 WAIT, then a clean block.
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, 128'd0, 1'b0, acc_a);
        wait_start(4'd6);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, stub_exp(pt), 1'b1, acc_a);
        wait_drain();

        // FIPS-197 C.1 through the real round function.
        aes_mode = 1'b1;
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        send_block(128'h00112233445566778899aabbccddeeff,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, acc_a);
        wait_drain();

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
